// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   state_e : controller FSM states
//   SLICE_W : width of one datapath slice (the 4-bit adder cell)
package adder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 4;
endpackage

// File: rtl/adder.sv
// 4-bit adder cell: {cout, sum} = a + b + cin. Purely combinational.
//   a, b : 4-bit operands
//   cin  : carry-in
//   sum  : 4-bit sum
//   cout : carry-out
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial wide adder controller. Reuses one 4-bit adder cell over
// NSLICE cycles, rippling the carry through a register.
//   clk, rst                : clock, asynchronous active-high reset
//   start_valid/start_ready : operand handshake (a, b, cin sampled on accept)
//   sum, cout               : registered result
//   done_valid/done_ready   : result handshake
//   busy                    : high in RUN or DONE
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("adder_seq_ctrl: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               carry_q, carry_d, cout_q, cout_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               start_ready_q, start_ready_d;
    logic               busy_q, busy_d;
    logic               done_valid_q, done_valid_d;

    logic [SLICE_W-1:0] cell_a, cell_b, cell_sum;
    logic               cell_cout;

    assign cell_a = a_q[SLICE_W*idx_q +: SLICE_W];
    assign cell_b = b_q[SLICE_W*idx_q +: SLICE_W];

    adder u_adder (
        .a    (cell_a),
        .b    (cell_b),
        .cin  (carry_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[SLICE_W*idx_q +: SLICE_W] = cell_sum;
                carry_d = cell_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = cell_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // Return to IDLE first; a pending start is taken next edge.
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake/status outputs are registered decodes of the next state.
        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        done_valid_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            sum_q         <= '0;
            carry_q       <= 1'b0;
            cout_q        <= 1'b0;
            idx_q         <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sum_q         <= sum_d;
            carry_q       <= carry_d;
            cout_q        <= cout_d;
            idx_q         <= idx_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            done_valid_q  <= done_valid_d;
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign done_valid  = done_valid_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
endmodule
